lsu_port: RTL and testbench

Load/store requester between the execute stage and the byte-masked 64-bit memory port. It accepts one load or store at a time and drives an 8-byte-aligned memory request with a lane-shifted write mask and data. It waits for completion, then returns the addressed sub-word, sign- or zero-extended. It is the initiator counterpart of the memory responder, and owns all alignment, masking and extension so the memory side only ever sees doubleword lanes.

---
 rtl/lsu_port_if.sv | 55 +++++
 rtl/lsu_port.sv | 167 ++++++++++++++++
 tb/tb_lsu_port.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_port_if.sv
// lsu_port_if: execute-side request/response bundle and
// doubleword memory bus bundle used by lsu_port.

interface lsu_req_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_wen, req_size,
    output req_unsigned, req_addr, req_wdata,
    output resp_ready,
    input  req_ready, resp_valid,
    input  resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_wen, req_size,
    input  req_unsigned, req_addr, req_wdata,
    input  resp_ready,
    output req_ready, resp_valid,
    output resp_rdata, resp_err
  );
endinterface

interface lsu_mem_if;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_wen;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;

  modport master (
    output mem_valid, mem_wen, mem_addr,
    output mem_wdata, mem_wmask,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_wen, mem_addr,
    input  mem_wdata, mem_wmask,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_port.sv
// lsu_port: single-outstanding load/store requester that
// aligns, masks and extends around a 64-bit memory port.

module lsu_port #(
  parameter int unsigned TIMEOUT = 256
) (
  input logic       clk,
  input logic       rst_n,
  lsu_req_if.slave  req,
  lsu_mem_if.master mem
);

  localparam int CW =
    (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE, REQ, WAIT, RESP
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic          rdy_q;
  logic [63:0]   addr_q;
  logic [63:0]   wdata_q;
  logic [63:0]   rdata_q;
  logic [1:0]    size_q;
  logic          wen_q;
  logic          uns_q;
  logic          err_q;
  logic [CW-1:0] cnt_q;

  logic [2:0]    in_off;
  logic [2:0]    off;
  logic          misal;
  logic          req_fire;
  logic          timeout_hit;
  logic [63:0]   shifted;
  logic [63:0]   load_val;
  logic [7:0]    mask;

  assign in_off   = req.req_addr[2:0];
  assign off      = addr_q[2:0];
  assign req_fire = req.req_valid & req.req_ready;
  assign timeout_hit =
    (TIMEOUT != 0) && (cnt_q == LAST);
  assign shifted  = mem.mem_rdata >> {off, 3'b000};

  // Natural-alignment check on the incoming request
  always_comb begin
    misal = 1'b0;
    unique case (req.req_size)
      2'd0:    misal = 1'b0;
      2'd1:    misal = in_off[0];
      2'd2:    misal = |in_off[1:0];
      default: misal = |in_off;
    endcase
  end

  // Truncate the lane-shifted read data and extend it
  always_comb begin
    load_val = shifted;
    unique case (size_q)
      2'd0: load_val =
        {{56{~uns_q & shifted[7]}}, shifted[7:0]};
      2'd1: load_val =
        {{48{~uns_q & shifted[15]}}, shifted[15:0]};
      2'd2: load_val =
        {{32{~uns_q & shifted[31]}}, shifted[31:0]};
      default: load_val = shifted;
    endcase
  end

  // Byte enables placed on the addressed lanes
  always_comb begin
    mask = 8'h00;
    unique case (size_q)
      2'd0:    mask = 8'b0000_0001 << off;
      2'd1:    mask = 8'b0000_0011 << off;
      2'd2:    mask = 8'b0000_1111 << off;
      default: mask = 8'hFF;
    endcase
  end

  // Next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (req_fire)
          state_nx = misal ? RESP : REQ;
      REQ:
        if (mem.mem_ready) state_nx = WAIT;
      WAIT:
        if (mem.mem_rvalid || timeout_hit)
          state_nx = RESP;
      RESP:
        if (req.resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register; rdy_q keeps req_ready low
  // for as long as reset is applied
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      rdy_q <= 1'b0;
    end else begin
      state <= state_nx;
      rdy_q <= 1'b1;
    end
  end

  // Captured request fields, result and wait counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      size_q  <= '0;
      wen_q   <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_fire) begin
            addr_q  <= req.req_addr;
            wdata_q <= req.req_wdata;
            size_q  <= req.req_size;
            wen_q   <= req.req_wen;
            uns_q   <= req.req_unsigned;
            rdata_q <= '0;
            err_q   <= misal;
          end
        end
        REQ: cnt_q <= '0;
        WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (mem.mem_rvalid) begin
            rdata_q <= wen_q ? '0 : load_val;
            err_q   <= 1'b0;
          end else if (timeout_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req.req_ready  = rdy_q & (state == IDLE);
  assign req.resp_valid = (state == RESP);
  assign req.resp_rdata = rdata_q;
  assign req.resp_err   = err_q;

  assign mem.mem_valid = (state == REQ);
  assign mem.mem_wen   = wen_q;
  assign mem.mem_addr  = {addr_q[63:3], 3'b000};
  assign mem.mem_wdata = wdata_q << {off, 3'b000};
  assign mem.mem_wmask = wen_q ? mask : 8'h00;

endmodule

// File: tb/tb_lsu_port.sv
// tb_lsu_port: directed and random load/store traffic
// against a byte-array reference memory and scoreboard.

module tb_lsu_port;

  localparam int TO = 4;
  localparam logic [63:0] BASE = 64'h8000_0000;

  typedef struct {
    logic [63:0] rdata;
    bit          err;
    int          lat;
    int          t0;
  } resp_t;

  typedef struct {
    logic [63:0] addr;
    bit          wen;
    logic [7:0]  wmask;
    logic [63:0] wdata;
  } mreq_t;

  typedef enum int { M_RAND, M_FAST, M_BP } mode_t;

  logic clk = 1'b0;
  logic rst_n;

  lsu_req_if r ();
  lsu_mem_if m ();

  lsu_port #(.TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (r.slave),
    .mem   (m.master)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  resp_t sq[$];
  mreq_t mq[$];
  logic [7:0]  ref_mem [512];
  logic [63:0] dmem [64];
  mode_t mode = M_RAND;
  bit no_resp = 1'b0;
  bit inject = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm, input string msg);
    vectors++;
    miscompares++;
    $display("FAIL %s: %s", nm, msg);
  endtask

  task automatic preset(input int idx, input logic [63:0] d);
    dmem[idx] = d;
    for (int i = 0; i < 8; i++)
      ref_mem[idx*8+i] = d[8*i +: 8];
  endtask

  // Reference: compute expectations from the spec's rules
  // using the byte-array memory, then drive and push.
  task automatic issue(input bit wen, input logic [1:0] size,
                       input bit uns, input logic [63:0] addr,
                       input logic [63:0] wdata, input bit chk);
    resp_t e;
    mreq_t q;
    int nb, off, bi, n;
    bit mis;
    logic [63:0] v;
    nb  = 1 << size;
    off = int'(addr[2:0]);
    bi  = int'(addr[8:0]);
    mis = (off % nb) != 0;
    q.addr  = {addr[63:3], 3'b000};
    q.wen   = wen;
    q.wdata = wdata << (8*off);
    q.wmask = 8'h00;
    for (int i = 0; i < nb; i++)
      if (wen && off + i < 8) q.wmask[off+i] = 1'b1;
    e.rdata = '0;
    e.err   = 1'b0;
    e.lat   = chk ? 3 : -1;
    e.t0    = 0;
    if (mis) begin
      e.err = 1'b1;
      e.lat = chk ? 1 : -1;
    end else if (no_resp) begin
      e.err = 1'b1;
      e.lat = chk ? 2 + TO : -1;
    end else if (wen) begin
      for (int i = 0; i < nb; i++)
        ref_mem[bi+i] = wdata[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < nb; i++)
        v = v | (64'(ref_mem[bi+i]) << (8*i));
      if (!uns && nb < 8 && v[8*nb-1])
        v = v | ({64{1'b1}} << (8*nb));
      e.rdata = v;
    end
    @(negedge clk);
    r.req_valid    = 1'b1;
    r.req_wen      = wen;
    r.req_size     = size;
    r.req_unsigned = uns;
    r.req_addr     = addr;
    r.req_wdata    = wdata;
    n = 0;
    while (r.req_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      flag("req_accept", "req_ready stuck at 0, want 1");
    end else begin
      e.t0 = cyc;
      sq.push_back(e);
      if (!mis) mq.push_back(q);
    end
    @(negedge clk);
    r.req_valid = 1'b0;
    r.req_addr  = {$urandom, $urandom};
    r.req_wdata = {$urandom, $urandom};
    r.req_size  = 2'($urandom_range(0, 3));
    r.req_wen   = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int n = 0;
    while ((sq.size() != 0 || mq.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) flag("drain", "transaction never completed");
    repeat (2) @(negedge clk);
  endtask

  // Memory responder: checks each presented request
  // and answers from a doubleword memory.
  initial begin : responder
    int pend;
    int bp;
    logic [63:0] pdata;
    pend = 0;
    bp = 0;
    pdata = '0;
    m.mem_ready  = 1'b0;
    m.mem_rvalid = 1'b0;
    m.mem_rdata  = '0;
    forever begin
      @(negedge clk);
      m.mem_rvalid = 1'b0;
      m.mem_rdata  = {$urandom, $urandom};
      if (inject) begin
        m.mem_rvalid = 1'b1;
        inject = 1'b0;
      end
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          m.mem_rvalid = 1'b1;
          m.mem_rdata  = pdata;
        end
      end
      if (m.mem_valid === 1'b1) begin
        if (mq.size() == 0) begin
          flag("mem_unexp", "mem_valid=1, want 0");
        end else begin
          check("mem_addr",  m.mem_addr,  mq[0].addr);
          check("mem_wen",   64'(m.mem_wen), 64'(mq[0].wen));
          check("mem_wmask", 64'(m.mem_wmask), 64'(mq[0].wmask));
          check("mem_wdata", m.mem_wdata, mq[0].wdata);
        end
      end
      case (mode)
        M_FAST:  m.mem_ready = 1'b1;
        M_BP:    m.mem_ready = (bp >= 5);
        default: m.mem_ready = ($urandom_range(0, 2) != 0);
      endcase
      if (m.mem_valid === 1'b1) bp++;
      if (m.mem_valid === 1'b1 && m.mem_ready
          && mq.size() != 0) begin
        void'(mq.pop_front());
        bp = 0;
        if (!no_resp) begin
          if (m.mem_wen) begin
            for (int i = 0; i < 8; i++)
              if (m.mem_wmask[i])
                dmem[m.mem_addr[8:3]][8*i +: 8] =
                  m.mem_wdata[8*i +: 8];
            pdata = {$urandom, $urandom};
          end else begin
            pdata = dmem[m.mem_addr[8:3]];
          end
          pend = (mode == M_RAND) ? $urandom_range(1, 3) : 1;
        end
      end
    end
  end

  // Response monitor: pops the scoreboard on each
  // accepted response and checks every RESP cycle.
  initial begin : monitor
    bit seen;
    bit rdy_next;
    int rv;
    seen = 1'b0;
    rdy_next = 1'b0;
    rv = 0;
    r.resp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rdy_next) begin
        check("req_ready_after", 64'(r.req_ready), 64'd1);
        rdy_next = 1'b0;
      end
      if (r.resp_valid === 1'b1) begin
        check("req_ready_busy", 64'(r.req_ready), 64'd0);
        if (sq.size() == 0) begin
          flag("resp_unexp", "resp_valid=1, want 0");
        end else begin
          if (!seen && sq[0].lat >= 0)
            check("latency", 64'(cyc - sq[0].t0),
                  64'(sq[0].lat));
          seen = 1'b1;
          check("resp_rdata", r.resp_rdata, sq[0].rdata);
          check("resp_err", 64'(r.resp_err), 64'(sq[0].err));
        end
      end
      case (mode)
        M_FAST:  r.resp_ready = 1'b1;
        M_BP:    r.resp_ready = (r.resp_valid === 1'b1) && rv >= 3;
        default: r.resp_ready = ($urandom_range(0, 2) != 0);
      endcase
      if (r.resp_valid === 1'b1) rv++;
      if (r.resp_valid === 1'b1 && r.resp_ready
          && sq.size() != 0) begin
        void'(sq.pop_front());
        seen = 1'b0;
        rv = 0;
        rdy_next = 1'b1;
      end
    end
  end

  initial begin : stimulus
    logic [63:0] a;
    logic [1:0]  sz;
    for (int i = 0; i < 64; i++)
      preset(i, {$urandom, $urandom});
    rst_n          = 1'b0;
    r.req_valid    = 1'b1;
    r.req_wen      = 1'b0;
    r.req_size     = 2'd0;
    r.req_unsigned = 1'b0;
    r.req_addr     = BASE;
    r.req_wdata    = '0;
    repeat (2) begin
      @(negedge clk);
      check("rst_req_ready", 64'(r.req_ready), 64'd0);
      check("rst_mem_valid", 64'(m.mem_valid), 64'd0);
      check("rst_resp_valid", 64'(r.resp_valid), 64'd0);
    end
    rst_n = 1'b1;
    r.req_valid = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", 64'(r.req_ready), 64'd1);
    check("post_rst_rdata", r.resp_rdata, 64'd0);
    check("post_rst_addr", m.mem_addr, 64'd0);
    check("post_rst_wdata", m.mem_wdata, 64'd0);
    check("post_rst_ctl",
          64'({m.mem_wmask, m.mem_wen, m.mem_valid,
               r.resp_err, r.resp_valid}), 64'd0);

    mode = M_FAST;
    issue(1'b1, 2'd0, 1'b0, BASE + 64'h5, 64'hAB, 1'b1);
    drain();
    preset(0, 64'h8001_0000_0000_0000);
    issue(1'b0, 2'd1, 1'b0, BASE + 64'h6, 64'h0, 1'b1);
    issue(1'b0, 2'd1, 1'b1, BASE + 64'h6, 64'h0, 1'b1);
    issue(1'b0, 2'd2, 1'b0, BASE + 64'h2, 64'h0, 1'b1);
    drain();

    mode = M_BP;
    issue(1'b1, 2'd2, 1'b0, BASE + 64'h10,
          {$urandom, $urandom}, 1'b0);
    issue(1'b0, 2'd2, 1'b0, BASE + 64'h10, 64'h0, 1'b0);
    drain();

    mode = M_FAST;
    no_resp = 1'b1;
    issue(1'b0, 2'd3, 1'b0, BASE + 64'h20, 64'h0, 1'b1);
    drain();
    no_resp = 1'b0;
    inject = 1'b1;
    repeat (4) @(negedge clk);
    issue(1'b0, 2'd3, 1'b0, BASE + 64'h20, 64'h0, 1'b1);
    drain();

    mode = M_RAND;
    for (int k = 0; k < 300; k++) begin
      a  = BASE + 64'($urandom_range(0, 511));
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0)
        a = a & ~((64'd1 << sz) - 64'd1);
      issue(1'($urandom_range(0, 1)), sz,
            1'($urandom_range(0, 1)), a,
            {$urandom, $urandom}, 1'b0);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
